// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the SimpleCPU run controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStart  = 2'd1,
        StRun    = 2'd2,
        StHalted = 2'd3
    } state_e;

    typedef enum logic {
        OwnHost = 1'b0,
        OwnCpu  = 1'b1
    } owner_e;

    localparam int unsigned DefHaltWindow = 16;
    localparam int unsigned DefMaxCycles  = 100000;

    function automatic owner_e ram_owner(state_e st);
        return (st == StStart || st == StRun) ? OwnCpu : OwnHost;
    endfunction

endpackage

// File: rtl/cpu_run_controller_pc_halt_detector.sv
// Declares halt once the CPU program counter has stayed put for HaltWindow RUN cycles.
module pc_halt_detector #(
    parameter int unsigned Size       = 14,
    parameter int unsigned HaltWindow = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            run_i,
    input  logic [Size-1:0] pc_i,
    output logic            halt_det_o
);
    localparam int unsigned CntW = $clog2(HaltWindow + 1);
    localparam logic [CntW-1:0] Window = CntW'(HaltWindow);

    logic [Size-1:0] pc_prev_q;
    logic [CntW-1:0] stable_q, stable_d;

    always_comb begin
        stable_d = stable_q;
        if (clear_i) begin
            stable_d = '0;
        end else if (run_i) begin
            if (pc_i != pc_prev_q) begin
                stable_d = '0;
            end else if (stable_q != Window) begin
                stable_d = stable_q + 1'b1;
            end
        end
    end

    assign halt_det_o = run_i && !clear_i && (stable_d == Window);

    // The START-cycle PC is captured so the first RUN cycle has a reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_prev_q <= '0;
            stable_q  <= '0;
        end else begin
            stable_q <= stable_d;
            if (clear_i || run_i) begin
                pc_prev_q <= pc_i;
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller and single-port RAM arbiter between the host/debug port and the SimpleCPU.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned Size       = 14,
    parameter int unsigned HaltWindow = DefHaltWindow,
    parameter int unsigned MaxCycles  = DefMaxCycles
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [Size-1:0] host_addr_i,
    input  logic [31:0]     host_wdata_i,
    output logic            host_gnt_o,
    output logic [31:0]     host_rdata_o,
    output logic            host_rvalid_o,
    output logic            cpu_rst_o,
    input  logic            cpu_wr_en_i,
    input  logic [Size-1:0] cpu_addr_i,
    input  logic [31:0]     cpu_wdata_i,
    input  logic [Size-1:0] cpu_pc_i,
    output logic [31:0]     cpu_rdata_o,
    output logic            ram_we_o,
    output logic [Size-1:0] ram_addr_o,
    output logic [31:0]     ram_wdata_o,
    input  logic [31:0]     ram_rdata_i,
    output logic            busy_o,
    output logic            halted_o,
    output logic            timeout_o,
    output logic            aborted_o,
    output logic [31:0]     cycle_count_o
);
    state_e      state_q;
    owner_e      owner;
    logic        cpu_rst_q, busy_q, halted_q, timeout_q, aborted_q, host_rvalid_q;
    logic [31:0] cycle_q, cycle_d;
    logic        halt_det, hit_max;

    pc_halt_detector #(
        .Size       (Size),
        .HaltWindow (HaltWindow)
    ) u_halt_det (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == StStart),
        .run_i      (state_q == StRun),
        .pc_i       (cpu_pc_i),
        .halt_det_o (halt_det)
    );

    assign owner   = ram_owner(state_q);
    assign cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
    assign hit_max = (cycle_d >= MaxCycles);

    // A start pulse claims the cycle, so a simultaneous host request is not granted.
    assign host_gnt_o = (owner == OwnHost) && host_req_i && !start_i;

    always_comb begin
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (owner == OwnCpu) begin
            ram_we_o    = cpu_wr_en_i;
            ram_addr_o  = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
        end else if (host_gnt_o) begin
            ram_we_o    = host_we_i;
            ram_addr_o  = host_addr_i;
            ram_wdata_o = host_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cpu_rst_q     <= 1'b1;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            aborted_q     <= 1'b0;
            cycle_q       <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            host_rvalid_q <= host_gnt_o && !host_we_i;
            unique case (state_q)
                StIdle, StHalted: begin
                    if (start_i) begin
                        state_q   <= StStart;
                        busy_q    <= 1'b1;
                        halted_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        aborted_q <= 1'b0;
                        cycle_q   <= '0;
                    end
                end
                StStart: begin
                    state_q   <= StRun;
                    cpu_rst_q <= 1'b0;
                end
                StRun: begin
                    cycle_q <= cycle_d;
                    if (abort_i || hit_max || halt_det) begin
                        state_q   <= StHalted;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        halted_q  <= 1'b1;
                        aborted_q <= abort_i;
                        timeout_q <= !abort_i && hit_max;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_rst_o     = cpu_rst_q;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign timeout_o     = timeout_q;
    assign aborted_o     = aborted_q;
    assign cycle_count_o = cycle_q;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rvalid_q ? ram_rdata_i : 32'd0;
    assign cpu_rdata_o   = ram_rdata_i;

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run controller and RAM-port arbiter for the SimpleCPU subsystem. While the CPU is held in reset, a host/debug port owns the single-port instruction/data RAM to load programs and read back results. On start, the block releases the CPU and gives it exclusive RAM ownership. It detects program halt (PC stuck), timeout or abort, then returns RAM ownership to the host.

Parameters:
SIZE, 14, RAM address width (matches CPU addr_toRAM/pCounter width)
HALT_WINDOW, 16, consecutive cycles with unchanged cpu_pc that declare halt (must be >4; the CPU holds PC for up to 4 cycles per instruction)
MAX_CYCLES, 100000, run-cycle limit before forced stop with timeout flag

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begin a run (accepted in IDLE/HALTED only)
abort  in  1  single-cycle pulse; stop a run (accepted in RUN only)
host_req  in  1  host RAM access request
host_we  in  1  host write enable (qualified by host_req)
host_addr  in  SIZE  host address
host_wdata  in  32  host write data
host_gnt  out  1  host access accepted this cycle
host_rdata  out  32  read data, valid with host_rvalid
host_rvalid  out  1  read data valid, one cycle after a granted read
cpu_rst  out  1  reset to CPU
cpu_wrEn  in  1  CPU write enable
cpu_addr  in  SIZE  CPU address
cpu_wdata  in  32  CPU write data
cpu_pc  in  SIZE  CPU program counter
cpu_rdata  out  32  read data to CPU (ram_rdata passthrough)
ram_we  out  1  RAM write enable
ram_addr  out  SIZE  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data (synchronous read, 1-cycle latency)
busy  out  1  high in START and RUN
halted  out  1  high in HALTED
timeout  out  1  sticky; set when the last run ended on MAX_CYCLES
aborted  out  1  sticky; set when the last run ended on abort
cycle_count  out  32  cycles spent in RUN for the last/current run, saturating

Behaviour:
- Reset: state IDLE, cpu_rst=1, host_gnt=0, host_rvalid=0, host_rdata=0, busy=0, halted=0, timeout=0, aborted=0, cycle_count=0, stable counter=0. rst mid-run aborts immediately to IDLE. No flag is set.
- States: IDLE -> START on start. START -> RUN after exactly 1 cycle. RUN -> HALTED on halt detect, timeout or abort. HALTED -> START on start.
- IDLE/HALTED: cpu_rst=1; host owns RAM; host_gnt = host_req (combinational); ram_we = host_req & host_we; ram_addr/ram_wdata from host. When no host_req: ram_we=0, ram_addr=0.
- host_rvalid registered: asserted the cycle after a granted read (host_req & ~host_we). host_rdata = ram_rdata in that cycle. Granted writes produce no rvalid.
- START (1 cycle): cpu_rst=1; RAM owned by CPU mux; cycle_count, stable counter, timeout and aborted cleared; host_gnt=0.
- RUN: cpu_rst=0; ram_we/addr/wdata = cpu_wrEn/cpu_addr/cpu_wdata; host_gnt=0. Host requests are stalled and not queued; the host holds host_req until granted.
- cpu_rdata = ram_rdata in all states.
- Halt detect: pc_prev is registered each RUN cycle. stable count increments when cpu_pc==pc_prev and resets to 0 otherwise. Reaching HALT_WINDOW -> HALTED next cycle. The first RUN cycle compares against the START-cycle PC value.
- cycle_count increments every RUN cycle and saturates at 2^32-1. Reaching MAX_CYCLES -> HALTED with timeout=1.
- Priority, if simultaneous in one RUN cycle: abort > timeout > halt. Only the winning flag is set.
- start in IDLE/HALTED together with host_req: start wins, host_gnt=0. An in-flight read still completes its rvalid next cycle.
- start during START/RUN is ignored. abort outside RUN is ignored.
- On leaving RUN, cpu_rst asserts in the first HALTED cycle. Any CPU write presented in the last RUN cycle is committed.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding: IDLE=0, START=1, RUN=2, HALTED=3
  - RAM owner select constants: OWN_HOST, OWN_CPU
  - default HALT_WINDOW and MAX_CYCLES constants
- One sub-module, pc_halt_detector: pc_prev register, stable counter, halt_det output, clear input. The FSM, arbiter mux and flags stay in the top.

Test Plan:
- Host load/readback in IDLE: write 0x0000_00AB to addr 5 -> host_gnt=1 same cycle. Read addr 5 -> host_rvalid next cycle with host_rdata=0x0000_00AB. cpu_rst=1 throughout.
- Run to halt: load a program ending in a BZJi self-loop at addr 3, pulse start -> cpu_rst low from the 2nd cycle. When PC sits at 3 for 16 cycles -> halted=1, cpu_rst=1, timeout=0. Host reads the result address and gets the expected value.
- Timeout: MAX_CYCLES=50, infinite incrementing loop -> halted=1, timeout=1, cycle_count=50.
- Abort and host stall: host_req held during RUN -> host_gnt=0. Pulse abort -> next cycle HALTED, aborted=1, host_gnt=1 while req is still held.
- Collisions: start with host_req in IDLE -> no grant, START entered. Abort and timeout in the same cycle -> aborted=1, timeout=0.
- rst asserted mid-RUN -> next cycle IDLE, cpu_rst=1, all flags 0, cycle_count=0. A second start runs normally.
